// File: rtl/alu_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_sweep_checker                                            |
// | Description : Drives every (C, X, Y) vector into the ALU and compares the  |
// |               structural result against the behavioural reference.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_sweep_checker #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N-1:0]     x_out,
  output logic [N-1:0]     y_out,
  output logic [2:0]       c_out,
  input  logic [N+1:0]     alu_o,
  input  logic [N+1:0]     ref_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*N+3:0]   err_count,
  output logic             first_fail_valid,
  output logic [2*N+2:0]   first_fail_vec
);

  localparam int VW = 2*N + 3;
  localparam int EW = 2*N + 4;
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] c_SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [VW-1:0]   r_v;
  logic [SW-1:0]   r_settle;
  logic [EW-1:0]   r_err;
  logic            r_ffv;
  logic [VW-1:0]   r_ffvec;
  logic            w_launch;
  logic            w_sample;
  logic            w_advance;
  logic            w_mismatch;

  assign w_mismatch = (alu_o != ref_o);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_sample    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_DRIVE;
          w_launch    = 1'b1;
        end
      end
      S_DRIVE: begin
        if (r_settle == c_SETTLE_LAST) w_state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        w_sample = 1'b1;
        if (&r_v) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRIVE;
          w_advance   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector, settle timer and result accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v      <= '0;
      r_settle <= '0;
      r_err    <= '0;
      r_ffv    <= 1'b0;
      r_ffvec  <= '0;
    end else begin
      if (w_launch) begin
        r_v      <= '0;
        r_settle <= '0;
        r_err    <= '0;
        r_ffv    <= 1'b0;
      end else if (r_state == S_DRIVE) begin
        r_settle <= r_settle + SW'(1);
      end
      if (w_sample && w_mismatch) begin
        r_err <= r_err + EW'(1);
        if (!r_ffv) begin
          r_ffv   <= 1'b1;
          r_ffvec <= r_v;
        end
      end
      if (w_advance) begin
        r_v      <= r_v + VW'(1);
        r_settle <= '0;
      end
    end
  end

  assign c_out            = r_v[VW-1:2*N];
  assign x_out            = r_v[2*N-1:N];
  assign y_out            = r_v[N-1:0];
  assign busy             = (r_state == S_DRIVE) || (r_state == S_COMPARE);
  assign done             = (r_state == S_DONE);
  assign pass             = done && (r_err == '0);
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_checker.sv
`default_nettype none
// Directed bench: two checker instances (SETTLE=1 and SETTLE=3) around a
// behavioural ALU model, with an optional inverted-reference fault on opcode 5.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic fault = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_model(input logic [2:0] c, input logic [3:0] x, input logic [3:0] y);
    case (c)
      3'd0:    return {2'b00, x} + {2'b00, y};
      3'd1:    return {2'b00, x} - {2'b00, y};
      3'd2:    return {2'b00, x & y};
      3'd3:    return {2'b00, x | y};
      3'd4:    return {2'b00, x ^ y};
      3'd5:    return {1'b0, x, 1'b0};
      3'd6:    return {2'b10, ~x};
      default: return {2'b01, y};
    endcase
  endfunction

  logic [3:0]  x1, y1, x3, y3;
  logic [2:0]  c1, c3;
  logic [5:0]  alu1, ref1, alu3, ref3;
  logic        busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3;
  logic [11:0] err1, err3;
  logic [10:0] vec1, vec3;

  assign alu1 = alu_model(c1, x1, y1);
  assign ref1 = alu1 ^ ((fault && c1 == 3'b101) ? 6'h3F : 6'h00);
  assign alu3 = alu_model(c3, x3, y3);
  assign ref3 = alu3 ^ ((fault && c3 == 3'b101) ? 6'h3F : 6'h00);

  alu_sweep_checker #(.N(4), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .x_out(x1), .y_out(y1), .c_out(c1), .alu_o(alu1), .ref_o(ref1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(vec1)
  );

  alu_sweep_checker #(.N(4), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .x_out(x3), .y_out(y3), .c_out(c3), .alu_o(alu3), .ref_o(ref3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_valid(ffv3), .first_fail_vec(vec3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after an edge's negedge; start is seen by the next edge k.
  task automatic pulse1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic pulse3();
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  initial begin
    step(2);
    check("reset_busy", {31'd0, busy1}, 32'd0);
    check("reset_done", {31'd0, done1}, 32'd0);
    check("reset_vec_out", {21'd0, c1, x1, y1}, 32'd0);
    check("reset_err", {20'd0, err1}, 32'd0);
    reset = 1'b0;
    step(1);

    // Clean sweep with vector-order checks; times are relative to edge k.
    pulse1();
    check("clean_busy_k1", {31'd0, busy1}, 32'd1);
    check("first_vec", {21'd0, c1, x1, y1}, 32'h000);
    step(2);
    check("y_after_2", {28'd0, y1}, 32'd1);
    step(30);
    check("xy_after_32", {24'd0, x1, y1}, 32'h10);
    step(4063);
    check("final_vec", {21'd0, c1, x1, y1}, 32'h7FF);
    check("clean_not_done_4095", {31'd0, done1}, 32'd0);
    step(1);
    check("clean_done_4096", {31'd0, done1}, 32'd1);
    check("clean_busy_off", {31'd0, busy1}, 32'd0);
    check("clean_pass", {31'd0, pass1}, 32'd1);
    check("clean_err", {20'd0, err1}, 32'd0);
    check("clean_ffv", {31'd0, ffv1}, 32'd0);
    check("clean_hold_last", {21'd0, c1, x1, y1}, 32'h7FF);

    // Faulted sweep restarted from DONE, with ignored starts at cycles 10 and 500.
    fault = 1'b1;
    pulse1();
    check("restart_busy", {31'd0, busy1}, 32'd1);
    check("restart_done_clr", {31'd0, done1}, 32'd0);
    check("restart_pass_low", {31'd0, pass1}, 32'd0);
    step(9);
    pulse1();
    step(489);
    pulse1();
    step(3595);
    check("fault_not_done_4095", {31'd0, done1}, 32'd0);
    step(1);
    check("fault_done_4096", {31'd0, done1}, 32'd1);
    check("fault_err", {20'd0, err1}, 32'd256);
    check("fault_vec", {21'd0, vec1}, 32'h500);
    check("fault_ffv", {31'd0, ffv1}, 32'd1);
    check("fault_pass", {31'd0, pass1}, 32'd0);

    // Asynchronous reset mid-sweep.
    pulse1();
    step(999);
    check("pre_reset_busy", {31'd0, busy1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", {31'd0, busy1}, 32'd0);
    check("async_done_pass", {30'd0, done1, pass1}, 32'd0);
    check("async_vec_out", {21'd0, c1, x1, y1}, 32'd0);
    check("async_err", {20'd0, err1}, 32'd0);
    check("async_ffv", {31'd0, ffv1}, 32'd0);
    check("async_ffvec", {21'd0, vec1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fault = 1'b0;
    step(1);
    pulse1();
    step(4095);
    check("post_reset_not_done", {31'd0, done1}, 32'd0);
    step(1);
    check("post_reset_done", {31'd0, done1}, 32'd1);
    check("post_reset_pass", {31'd0, pass1}, 32'd1);

    // SETTLE=3: faulted sweep, then restart from DONE.
    fault = 1'b1;
    pulse3();
    check("s3_busy", {31'd0, busy3}, 32'd1);
    step(4);
    check("s3_y_after_4", {28'd0, y3}, 32'd1);
    step(8187);
    check("s3_not_done_8191", {31'd0, done3}, 32'd0);
    step(1);
    check("s3_done_8192", {31'd0, done3}, 32'd1);
    check("s3_err", {20'd0, err3}, 32'd256);
    check("s3_pass", {31'd0, pass3}, 32'd0);
    pulse3();
    check("s3_restart_err_clr", {20'd0, err3}, 32'd0);
    check("s3_restart_ffv_clr", {31'd0, ffv3}, 32'd0);
    check("s3_restart_busy", {31'd0, busy3}, 32'd1);
    step(8191);
    check("s3_re_not_done", {31'd0, done3}, 32'd0);
    step(1);
    check("s3_re_done", {31'd0, done3}, 32'd1);
    check("s3_re_err", {20'd0, err3}, 32'd256);
    check("s3_re_vec", {21'd0, vec3}, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sweep_checker.md
Name: alu_sweep_checker

Overview:
- Sequential stimulus-and-compare stage wrapped around the multifunction ALU.
- Drives the ALU operand/opcode inputs with an exhaustive sweep of every (C, X, Y) combination.
- Samples the structural ALU result against the behavioural ALU result and accumulates a mismatch count, the first failing vector, and a final pass flag.
- Sits directly upstream of the ALU (feeds X, Y, C) and directly downstream of it (consumes O).

Parameters:
- N, 4, operand width; matches the ALU width parameter.
- SETTLE, 1, cycles the vector is held before sampling; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- x_out  output  N  operand X to the ALU, two's complement.
- y_out  output  N  operand Y to the ALU, two's complement.
- c_out  output  3  opcode C to the ALU.
- alu_o  input  N+2  structural ALU result.
- ref_o  input  N+2  behavioural ALU result for the same X, Y, C.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until restart or reset.
- pass  output  1  valid while done; 1 iff err_count==0.
- err_count  output  2N+4  number of mismatching vectors.
- first_fail_valid  output  1  first_fail_vec holds a captured vector.
- first_fail_vec  output  2N+3  {c, x, y} of the first mismatch.

Behaviour:
- Reset (asynchronous, immediate, including mid-sweep):
  - state=IDLE.
  - Vector index v=0; x_out, y_out, c_out all 0.
  - busy, done, pass all 0.
  - err_count=0, first_fail_valid=0, first_fail_vec=0.
- Vector index v is 2N+3 bits. Mapping: c=v[2N+2:2N], x=v[2N-1:N], y=v[N-1:0]. Y increments fastest, then X, then C.
- x_out, y_out and c_out are registered copies of v.
- FSM states: IDLE, DRIVE, COMPARE, DONE.
  - IDLE: on start=1 at edge k → v=0; err_count, first_fail_valid and done cleared; settle counter=0; state DRIVE, busy=1. Outputs show v=0 after edge k.
  - DRIVE: the settle counter increments each edge. After SETTLE edges in DRIVE → COMPARE.
  - COMPARE (one cycle): compare alu_o with ref_o across all N+2 bits.
    - On mismatch: err_count+1.
    - On mismatch with first_fail_valid==0: capture first_fail_vec=v and set first_fail_valid=1.
    - If v is not all-ones: v+1 (new vector on outputs), settle counter=0, state DRIVE.
    - If v is all-ones: state DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). The final vector's compare result is included. x_out, y_out and c_out hold the last vector. start=1 restarts exactly as from IDLE, in the same cycle.
- Per-vector period is SETTLE+1 cycles. done is first visible after edge k + 2^(2N+3)·(SETTLE+1). For N=4, SETTLE=1 that is 4096 edges.
- start while busy is ignored: no restart, no counter effect.
- err_count width 2N+4 exceeds the vector count 2^(2N+3), so no overflow or saturation is needed.
- pass is 0 whenever done=0.
- Inputs alu_o and ref_o are sampled only in COMPARE; their values in other states are don't-care.

Test Plan:
- Clean sweep: N=4, SETTLE=1, ref_o tied to a correct behavioural model, start pulsed at edge k.
  - Required: busy=1 from k+1; done=1 after edge k+4096; pass=1; err_count=0; first_fail_valid=0.
- Vector order: after start, watch the outputs.
  - First vector: x_out=0, y_out=0, c_out=0.
  - Two cycles later: y_out=1.
  - After 32 cycles: x_out=1, y_out=0.
  - Final vector: c_out=7, x_out=4'hF, y_out=4'hF.
- Injected fault: ref_o inverted whenever c_out==3'b101.
  - Required: err_count=256, first_fail_vec=11'h500, first_fail_valid=1, pass=0 at done.
- Start while busy: extra start pulses at cycles 10 and 500 of a sweep.
  - Required: done timing unchanged (k+4096); err_count unaffected.
- Reset mid-sweep: assert reset at cycle 1000 between clock edges.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - A later start completes a full 4096-cycle sweep.
- Restart and SETTLE: instantiate SETTLE=3, run a faulted sweep, then pulse start in DONE.
  - Required: err_count and first_fail_valid cleared on the restart edge; done after 8192 edges.
